// File: rtl/hiera_cla_adder16.sv
// hiera_cla_adder16 -- 16-bit two-level carry-lookahead adder with registered result.
// Four 4-bit lookahead groups report group propagate/generate to a second-level
// lookahead unit. That unit derives every group carry-in directly from c_in, so
// no carry ripples from one group to the next.

// Bit-level propagate/generate for all 16 operand bits.
module hiera_cla_pg16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] p_o,
  output logic [15:0] g_o
);

  // Half-adder terms per bit. XOR propagate is reused directly for the sum.
  always_comb begin
    p_o = a_i ^ b_i;
    g_o = a_i & b_i;
  end

endmodule

// One 4-bit lookahead group: internal carries plus group propagate/generate.
module hiera_cla_group4 (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       c_i,
  output logic [3:0] carry_o,
  output logic       gp_o,
  output logic       gg_o
);

  // Flattened lookahead carries into each bit of the group. Bit 0 takes the group carry-in.
  always_comb begin
    carry_o[0] = c_i;
    carry_o[1] = g_i[0]
               | (p_i[0] & c_i);
    carry_o[2] = g_i[1]
               | (p_i[1] & g_i[0])
               | (p_i[1] & p_i[0] & c_i);
    carry_o[3] = g_i[2]
               | (p_i[2] & g_i[1])
               | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & c_i);
  end

  // Group terms for the second level. They do not depend on the group carry-in.
  always_comb begin
    gp_o = &p_i;
    gg_o = g_i[3]
         | (p_i[3] & g_i[2])
         | (p_i[3] & p_i[2] & g_i[1])
         | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  end

endmodule

// Second-level lookahead unit. Carries into groups 1..3 and the final carry-out.
module hiera_cla_lcu4 (
  input  logic [3:0] gp_i,
  input  logic [3:0] gg_i,
  input  logic       c0_i,
  output logic       c4_o,
  output logic       c8_o,
  output logic       c12_o,
  output logic       c16_o
);

  // Every carry is expanded back to c0_i so no carry waits on the carry below it.
  always_comb begin
    c4_o  = gg_i[0]
          | (gp_i[0] & c0_i);
    c8_o  = gg_i[1]
          | (gp_i[1] & gg_i[0])
          | (gp_i[1] & gp_i[0] & c0_i);
    c12_o = gg_i[2]
          | (gp_i[2] & gg_i[1])
          | (gp_i[2] & gp_i[1] & gg_i[0])
          | (gp_i[2] & gp_i[1] & gp_i[0] & c0_i);
    c16_o = gg_i[3]
          | (gp_i[3] & gg_i[2])
          | (gp_i[3] & gp_i[2] & gg_i[1])
          | (gp_i[3] & gp_i[2] & gp_i[1] & gg_i[0])
          | (gp_i[3] & gp_i[2] & gp_i[1] & gp_i[0] & c0_i);
  end

endmodule

// Top level. Combinational two-level CLA core followed by the output register.
module hiera_cla_adder16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] add_1,
  input  logic [15:0] add_2,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] carry;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_cin;
  logic        c4;
  logic        c8;
  logic        c12;
  logic        c16;
  logic [15:0] sum_d;
  logic [15:0] sum_q;
  logic        c_out_d;
  logic        c_out_q;

  hiera_cla_pg16 u_pg (
    .a_i (add_1),
    .b_i (add_2),
    .p_o (p),
    .g_o (g)
  );

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_grp
      hiera_cla_group4 u_grp (
        .p_i     (p[4*k +: 4]),
        .g_i     (g[4*k +: 4]),
        .c_i     (grp_cin[k]),
        .carry_o (carry[4*k +: 4]),
        .gp_o    (grp_p[k]),
        .gg_o    (grp_g[k])
      );
    end
  endgenerate

  hiera_cla_lcu4 u_lcu (
    .gp_i  (grp_p),
    .gg_i  (grp_g),
    .c0_i  (c_in),
    .c4_o  (c4),
    .c8_o  (c8),
    .c12_o (c12),
    .c16_o (c16)
  );

  // Group carry-ins come only from the lookahead unit, never from the group below.
  always_comb begin
    grp_cin = {c12, c8, c4, c_in};
  end

  // Sum bits and carry-out are presented to the output register.
  always_comb begin
    sum_d   = p ^ carry;
    c_out_d = c16;
  end

  // Output register. Reset clears the result at once and discards any in-flight value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 16'h0000;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_hiera_cla_adder16.sv
// Scoreboard bench for hiera_cla_adder16. The driver pushes the expected 17-bit
// result for every operand set. The monitor pops one entry after each rising
// edge and compares it against {c_out, sum}.
module tb_hiera_cla_adder16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] add_1 = '0;
  logic [15:0] add_2 = '0;
  logic        c_in = 1'b0;
  logic [15:0] sum;
  logic        c_out;

  int tests  = 0;
  int failed = 0;

  logic [16:0] exp_q[$];

  hiera_cla_adder16 dut (
    .clk   (clk),
    .rst   (rst),
    .add_1 (add_1),
    .add_2 (add_2),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got c_out=%0b sum=0x%04h, expected c_out=%0b sum=0x%04h",
               name, got[16], got[15:0], exp[16], exp[15:0]);
    end
  endtask

  // The reference is a plain 17-bit arithmetic sum.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    int unsigned s;
    s = int'(a) + int'(b) + int'(c);
    return s[16:0];
  endfunction

  // Applies an operand set between edges and queues the result required after the next edge.
  task automatic drive_exp(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [16:0] exp);
    @(negedge clk);
    add_1 = a;
    add_2 = b;
    c_in  = c;
    exp_q.push_back(exp);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
    drive_exp(a, b, c, ref_add(a, b, c));
  endtask

  // Waits, with a bounded cycle budget, until the monitor has consumed every queued result.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one result per rising edge while results are pending and reset is low.
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (!rst && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pipe", {c_out, sum}, e);
    end
  end

  initial begin
    // Reset is asserted between edges, so the clear must not need a clock.
    #1;
    rst   = 1'b1;
    add_1 = 16'd432;
    add_2 = 16'd765;
    c_in  = 1'b1;
    #1;
    check("reset_async", {c_out, sum}, 17'h0_0000);
    @(posedge clk);
    #1;
    check("reset_hold", {c_out, sum}, 17'h0_0000);

    // Releasing reset lets the next edge capture 432 + 765 + 1.
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({1'b0, 16'h04AE});
    drain();

    // Carry-in effect.
    drive_exp(16'd432, 16'd765, 1'b0, {1'b0, 16'h04AD});
    // Near overflow, then full propagate through every group.
    drive_exp(16'd65534, 16'd1, 1'b0, {1'b0, 16'hFFFF});
    drive_exp(16'd65534, 16'd1, 1'b1, {1'b1, 16'h0000});
    // Back-to-back operand sets, one per cycle.
    drive_exp(16'h00FF, 16'h0001, 1'b0, {1'b0, 16'h0100});
    drive_exp(16'h0FFF, 16'h0001, 1'b0, {1'b0, 16'h1000});
    drive_exp(16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000});
    drive_exp(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF});
    // Remaining boundary cases.
    drive_exp(16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000});
    drive_exp(16'h0000, 16'h0000, 1'b0, {1'b0, 16'h0000});
    drive_exp(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555});
    drain();

    // Mid-stream reset while a nonzero result is held.
    drive_exp(16'h1234, 16'h0F0F, 1'b1, {1'b0, 16'h2144});
    drain();
    rst = 1'b1;
    #1;
    check("midreset_async", {c_out, sum}, 17'h0_0000);
    @(posedge clk);
    #1;
    check("midreset_hold", {c_out, sum}, 17'h0_0000);
    @(negedge clk);
    rst = 1'b0;
    add_1 = 16'hA5A5;
    add_2 = 16'h5A5B;
    c_in  = 1'b0;
    #1;
    check("midreset_release", {c_out, sum}, 17'h0_0000);
    exp_q.push_back({1'b1, 16'h0000});
    drain();

    // Random operand sets, one per cycle. Every eighth set uses extreme operands.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if ((i % 8) == 0) begin
        a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
        b = ~a ^ 16'($urandom_range(0, 1));
      end
      drive(a, b, c);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish before time limit");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "timeout");
  end

endmodule
